// File: rtl/tl_uncached_fetch_adapter.sv
// Uncached TileLink fetch requester: turns simple read requests into Get/GetBlock acquires
// and queues the returning grant beats in a small response FIFO. Optional beat checking: TL_FETCH_CHECK_EN.
module tl_uncached_fetch_adapter #(
    parameter int ADDR_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              io_req_ready,
    input  logic              io_req_valid,
    input  logic [ADDR_W-1:0] io_req_bits_addr,
    input  logic              io_req_bits_block,
    input  logic              io_resp_ready,
    output logic              io_resp_valid,
    output logic [63:0]       io_resp_bits_data,
    output logic [2:0]        io_resp_bits_beat,
    output logic              io_resp_bits_last,
    input  logic              io_acquire_ready,
    output logic              io_acquire_valid,
    output logic [ADDR_W-7:0] io_acquire_bits_addr_block,
    output logic [1:0]        io_acquire_bits_client_xact_id,
    output logic [2:0]        io_acquire_bits_addr_beat,
    output logic              io_acquire_bits_is_builtin_type,
    output logic [2:0]        io_acquire_bits_a_type,
    output logic [11:0]       io_acquire_bits_union,
    output logic [63:0]       io_acquire_bits_data,
    output logic              io_grant_ready,
    input  logic              io_grant_valid,
    input  logic [2:0]        io_grant_bits_addr_beat,
    input  logic [1:0]        io_grant_bits_client_xact_id,
    input  logic [3:0]        io_grant_bits_g_type,
    input  logic [63:0]       io_grant_bits_data,
    output logic              io_error
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RESP_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_GNT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              block_q, block_d;
    logic [1:0]        xact_id_q, xact_id_d;
    logic [2:0]        beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // Entry layout: {data[63:0], beat[2:0], last}
    logic [67:0]       fifo_mem [RESP_DEPTH];
    logic [67:0]       fifo_head;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              grant_last;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign push       = io_grant_valid & io_grant_ready;
    assign pop        = io_resp_valid & io_resp_ready;
    assign grant_last = ~block_q | (beat_cnt_q == 3'd7);

    assign io_req_ready                    = (state_q == S_IDLE);
    assign io_acquire_valid                = (state_q == S_ACQ);
    assign io_grant_ready                  = (state_q == S_GNT) & ~fifo_full;
    assign io_acquire_bits_addr_block      = addr_q[ADDR_W-1:6];
    assign io_acquire_bits_client_xact_id  = xact_id_q;
    assign io_acquire_bits_addr_beat       = block_q ? 3'd0 : addr_q[5:3];
    assign io_acquire_bits_is_builtin_type = 1'b1;
    assign io_acquire_bits_a_type          = block_q ? 3'd1 : 3'd0;
    assign io_acquire_bits_union           = block_q ? 12'd1 : {addr_q[2:0], 3'd3, 6'd0};
    assign io_acquire_bits_data            = 64'd0;

    assign io_resp_valid     = (count_q != '0);
    assign io_resp_bits_data = fifo_head[67:4];
    assign io_resp_bits_beat = fifo_head[3:1];
    assign io_resp_bits_last = fifo_head[0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        block_d    = block_q;
        xact_id_d  = xact_id_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (io_req_valid) begin
                    addr_d  = io_req_bits_addr;
                    block_d = io_req_bits_block;
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (io_acquire_ready) begin
                    beat_cnt_d = 3'd0;
                    state_d    = S_GNT;
                end
            end
            S_GNT: begin
                if (push) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (grant_last) begin
                        xact_id_d = xact_id_q + 2'd1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            block_q    <= 1'b0;
            xact_id_q  <= 2'd0;
            beat_cnt_q <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            block_q    <= block_d;
            xact_id_q  <= xact_id_d;
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is not reset; occupancy (count_q) alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {io_grant_bits_data, io_grant_bits_addr_beat, grant_last};
        end
    end

`ifdef TL_FETCH_CHECK_EN
    logic error_q, error_d;
    logic grant_bad;

    always_comb begin
        grant_bad = push & ((io_grant_bits_client_xact_id != xact_id_q) |
                            (io_grant_bits_g_type != (block_q ? 4'd5 : 4'd4)) |
                            (io_grant_bits_addr_beat != (block_q ? beat_cnt_q : addr_q[5:3])));
        error_d   = error_q | grant_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && grant_bad) begin
            $display("tl_uncached_fetch_adapter: unexpected grant id=%0d g_type=%0d beat=%0d",
                     io_grant_bits_client_xact_id, io_grant_bits_g_type, io_grant_bits_addr_beat);
        end
    end
`endif

    assign io_error = error_q;
`else
    logic unused_grant_fields;
    assign unused_grant_fields = ^{io_grant_bits_client_xact_id, io_grant_bits_g_type};
    assign io_error = 1'b0;
`endif

endmodule

// File: tb/tb_tl_uncached_fetch_adapter.sv
// Directed bench for tl_uncached_fetch_adapter: Get, GetBlock, backpressure, id wrap, error flag, mid-reset.
module tb_tl_uncached_fetch_adapter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_ready;
    logic        io_req_valid = 1'b0;
    logic [31:0] io_req_bits_addr = '0;
    logic        io_req_bits_block = 1'b0;
    logic        io_resp_ready = 1'b0;
    logic        io_resp_valid;
    logic [63:0] io_resp_bits_data;
    logic [2:0]  io_resp_bits_beat;
    logic        io_resp_bits_last;
    logic        io_acquire_ready = 1'b0;
    logic        io_acquire_valid;
    logic [25:0] io_acquire_bits_addr_block;
    logic [1:0]  io_acquire_bits_client_xact_id;
    logic [2:0]  io_acquire_bits_addr_beat;
    logic        io_acquire_bits_is_builtin_type;
    logic [2:0]  io_acquire_bits_a_type;
    logic [11:0] io_acquire_bits_union;
    logic [63:0] io_acquire_bits_data;
    logic        io_grant_ready;
    logic        io_grant_valid = 1'b0;
    logic [2:0]  io_grant_bits_addr_beat = '0;
    logic [1:0]  io_grant_bits_client_xact_id = '0;
    logic [3:0]  io_grant_bits_g_type = '0;
    logic [63:0] io_grant_bits_data = '0;
    logic        io_error;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef TL_FETCH_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    tl_uncached_fetch_adapter #(.ADDR_W(32), .RESP_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
        .io_req_bits_addr(io_req_bits_addr), .io_req_bits_block(io_req_bits_block),
        .io_resp_ready(io_resp_ready), .io_resp_valid(io_resp_valid),
        .io_resp_bits_data(io_resp_bits_data), .io_resp_bits_beat(io_resp_bits_beat),
        .io_resp_bits_last(io_resp_bits_last),
        .io_acquire_ready(io_acquire_ready), .io_acquire_valid(io_acquire_valid),
        .io_acquire_bits_addr_block(io_acquire_bits_addr_block),
        .io_acquire_bits_client_xact_id(io_acquire_bits_client_xact_id),
        .io_acquire_bits_addr_beat(io_acquire_bits_addr_beat),
        .io_acquire_bits_is_builtin_type(io_acquire_bits_is_builtin_type),
        .io_acquire_bits_a_type(io_acquire_bits_a_type),
        .io_acquire_bits_union(io_acquire_bits_union),
        .io_acquire_bits_data(io_acquire_bits_data),
        .io_grant_ready(io_grant_ready), .io_grant_valid(io_grant_valid),
        .io_grant_bits_addr_beat(io_grant_bits_addr_beat),
        .io_grant_bits_client_xact_id(io_grant_bits_client_xact_id),
        .io_grant_bits_g_type(io_grant_bits_g_type),
        .io_grant_bits_data(io_grant_bits_data),
        .io_error(io_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic block);
        io_req_valid      = 1'b1;
        io_req_bits_addr  = addr;
        io_req_bits_block = block;
        tick();
        io_req_valid      = 1'b0;
    endtask

    task automatic accept_acq;
        io_acquire_ready = 1'b1;
        tick();
        io_acquire_ready = 1'b0;
    endtask

    task automatic send_grant(input logic [2:0] beat, input logic [1:0] id,
                              input logic [3:0] gt, input logic [63:0] data);
        for (int i = 0; i < 20 && !io_grant_ready; i++) tick();
        n_cmp++;
        if (io_grant_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_wait_timeout got=%0b exp=1", io_grant_ready);
        end
        io_grant_valid               = 1'b1;
        io_grant_bits_addr_beat      = beat;
        io_grant_bits_client_xact_id = id;
        io_grant_bits_g_type         = gt;
        io_grant_bits_data           = data;
        tick();
        io_grant_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (io_req_ready !== 1'b1)     begin n_bad++; $display("FAIL rst_req_ready got=%0b exp=1", io_req_ready); end
        n_cmp++; if (io_acquire_valid !== 1'b0) begin n_bad++; $display("FAIL rst_acq_valid got=%0b exp=0", io_acquire_valid); end
        n_cmp++; if (io_grant_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_grant_ready got=%0b exp=0", io_grant_ready); end
        n_cmp++; if (io_resp_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_resp_valid got=%0b exp=0", io_resp_valid); end
        n_cmp++; if (io_error !== 1'b0)         begin n_bad++; $display("FAIL rst_error got=%0b exp=0", io_error); end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (io_req_ready !== 1'b1)     begin n_bad++; $display("FAIL rel_req_ready got=%0b exp=1", io_req_ready); end
        $display("test_reset done");
    endtask

    task automatic test_get;
        send_req(32'h0000_1008, 1'b0);
        n_cmp++; if (io_req_ready !== 1'b0)                    begin n_bad++; $display("FAIL get_req_ready got=%0b exp=0", io_req_ready); end
        n_cmp++; if (io_acquire_valid !== 1'b1)                begin n_bad++; $display("FAIL get_acq_valid got=%0b exp=1", io_acquire_valid); end
        n_cmp++; if (io_acquire_bits_a_type !== 3'd0)          begin n_bad++; $display("FAIL get_a_type got=%0d exp=0", io_acquire_bits_a_type); end
        n_cmp++; if (io_acquire_bits_addr_block !== 26'h40)    begin n_bad++; $display("FAIL get_addr_block got=%0h exp=40", io_acquire_bits_addr_block); end
        n_cmp++; if (io_acquire_bits_addr_beat !== 3'd1)       begin n_bad++; $display("FAIL get_addr_beat got=%0d exp=1", io_acquire_bits_addr_beat); end
        n_cmp++; if (io_acquire_bits_union !== 12'h0C0)        begin n_bad++; $display("FAIL get_union got=%0h exp=0c0", io_acquire_bits_union); end
        n_cmp++; if (io_acquire_bits_client_xact_id !== 2'd0)  begin n_bad++; $display("FAIL get_xact_id got=%0d exp=0", io_acquire_bits_client_xact_id); end
        n_cmp++; if (io_acquire_bits_is_builtin_type !== 1'b1) begin n_bad++; $display("FAIL get_builtin got=%0b exp=1", io_acquire_bits_is_builtin_type); end
        n_cmp++; if (io_acquire_bits_data !== 64'd0)           begin n_bad++; $display("FAIL get_acq_data got=%0h exp=0", io_acquire_bits_data); end
        n_cmp++; if (io_grant_ready !== 1'b0)                  begin n_bad++; $display("FAIL get_grant_ready_acq got=%0b exp=0", io_grant_ready); end
        tick();
        n_cmp++; if (io_acquire_valid !== 1'b1)                begin n_bad++; $display("FAIL get_acq_hold got=%0b exp=1", io_acquire_valid); end
        accept_acq();
        n_cmp++; if (io_acquire_valid !== 1'b0)                begin n_bad++; $display("FAIL get_acq_drop got=%0b exp=0", io_acquire_valid); end
        n_cmp++; if (io_grant_ready !== 1'b1)                  begin n_bad++; $display("FAIL get_grant_ready got=%0b exp=1", io_grant_ready); end
        send_grant(3'd1, 2'd0, 4'd4, 64'hDEAD_BEEF_0000_1008);
        n_cmp++; if (io_resp_valid !== 1'b1)                   begin n_bad++; $display("FAIL get_resp_valid got=%0b exp=1", io_resp_valid); end
        n_cmp++; if (io_resp_bits_data !== 64'hDEAD_BEEF_0000_1008) begin n_bad++; $display("FAIL get_resp_data got=%0h exp=deadbeef00001008", io_resp_bits_data); end
        n_cmp++; if (io_resp_bits_beat !== 3'd1)               begin n_bad++; $display("FAIL get_resp_beat got=%0d exp=1", io_resp_bits_beat); end
        n_cmp++; if (io_resp_bits_last !== 1'b1)               begin n_bad++; $display("FAIL get_resp_last got=%0b exp=1", io_resp_bits_last); end
        n_cmp++; if (io_req_ready !== 1'b1)                    begin n_bad++; $display("FAIL get_idle_again got=%0b exp=1", io_req_ready); end
        io_resp_ready = 1'b1;
        tick();
        io_resp_ready = 1'b0;
        n_cmp++; if (io_resp_valid !== 1'b0)                   begin n_bad++; $display("FAIL get_resp_pop got=%0b exp=0", io_resp_valid); end
        $display("test_get done");
    endtask

    task automatic test_block;
        send_req(32'h0000_1000, 1'b1);
        n_cmp++; if (io_acquire_bits_a_type !== 3'd1)         begin n_bad++; $display("FAIL blk_a_type got=%0d exp=1", io_acquire_bits_a_type); end
        n_cmp++; if (io_acquire_bits_addr_beat !== 3'd0)      begin n_bad++; $display("FAIL blk_addr_beat got=%0d exp=0", io_acquire_bits_addr_beat); end
        n_cmp++; if (io_acquire_bits_union !== 12'd1)         begin n_bad++; $display("FAIL blk_union got=%0h exp=1", io_acquire_bits_union); end
        n_cmp++; if (io_acquire_bits_client_xact_id !== 2'd1) begin n_bad++; $display("FAIL blk_xact_id got=%0d exp=1", io_acquire_bits_client_xact_id); end
        accept_acq();
        io_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io_grant_valid               = 1'b1;
            io_grant_bits_addr_beat      = 3'(i);
            io_grant_bits_client_xact_id = 2'd1;
            io_grant_bits_g_type         = 4'd5;
            io_grant_bits_data           = 64'hA5A5_0000_0000_0000 + 64'(i);
            n_cmp++; if (io_grant_ready !== 1'b1) begin n_bad++; $display("FAIL blk_grant_ready[%0d] got=%0b exp=1", i, io_grant_ready); end
            tick();
            n_cmp++; if (io_resp_valid !== 1'b1 || io_resp_bits_beat !== 3'(i) ||
                         io_resp_bits_data !== 64'hA5A5_0000_0000_0000 + 64'(i) || io_resp_bits_last !== (i == 7)) begin
                n_bad++;
                $display("FAIL blk_resp[%0d] got v=%0b beat=%0d data=%0h last=%0b exp v=1 beat=%0d last=%0b",
                         i, io_resp_valid, io_resp_bits_beat, io_resp_bits_data, io_resp_bits_last, i, (i == 7));
            end
        end
        io_grant_valid = 1'b0;
        n_cmp++; if (io_req_ready !== 1'b1)  begin n_bad++; $display("FAIL blk_idle got=%0b exp=1", io_req_ready); end
        tick();
        n_cmp++; if (io_resp_valid !== 1'b0) begin n_bad++; $display("FAIL blk_drained got=%0b exp=0", io_resp_valid); end
        io_resp_ready = 1'b0;
        $display("test_block done");
    endtask

    task automatic test_backpressure;
        int next_g = 0;
        int rd = 0;
        logic fire_g, fire_r;
        send_req(32'h0000_2000, 1'b1);
        accept_acq();
        for (int cyc = 0; cyc < 80 && rd < 8; cyc++) begin
            io_resp_ready                = (cyc >= 6);
            io_grant_valid               = (next_g < 8);
            io_grant_bits_addr_beat      = 3'(next_g);
            io_grant_bits_client_xact_id = 2'd2;
            io_grant_bits_g_type         = 4'd5;
            io_grant_bits_data           = 64'hB000_0000_0000_0000 + 64'(next_g);
            if (cyc == 4) begin
                n_cmp++; if (io_grant_ready !== 1'b0) begin n_bad++; $display("FAIL bp_grant_ready_full got=%0b exp=0", io_grant_ready); end
                n_cmp++; if (next_g != 2)             begin n_bad++; $display("FAIL bp_beats_accepted got=%0d exp=2", next_g); end
                n_cmp++; if (io_resp_valid !== 1'b1 || io_resp_bits_beat !== 3'd0) begin
                    n_bad++; $display("FAIL bp_head got v=%0b beat=%0d exp v=1 beat=0", io_resp_valid, io_resp_bits_beat);
                end
            end
            fire_g = io_grant_valid & io_grant_ready;
            fire_r = io_resp_valid & io_resp_ready;
            if (fire_r) begin
                n_cmp++; if (io_resp_bits_beat !== 3'(rd) || io_resp_bits_data !== 64'hB000_0000_0000_0000 + 64'(rd) ||
                             io_resp_bits_last !== (rd == 7)) begin
                    n_bad++;
                    $display("FAIL bp_resp[%0d] got beat=%0d data=%0h last=%0b exp beat=%0d last=%0b",
                             rd, io_resp_bits_beat, io_resp_bits_data, io_resp_bits_last, rd, (rd == 7));
                end
                rd++;
            end
            if (fire_g) next_g++;
            tick();
        end
        io_grant_valid = 1'b0;
        io_resp_ready  = 1'b0;
        n_cmp++; if (rd != 8)                begin n_bad++; $display("FAIL bp_resp_count got=%0d exp=8", rd); end
        n_cmp++; if (io_resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%0b exp=0", io_resp_valid); end
        n_cmp++; if (io_req_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_idle got=%0b exp=1", io_req_ready); end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        io_resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_req(32'h0000_3000 + 32'(k * 8), 1'b0);
            n_cmp++; if (io_acquire_bits_client_xact_id !== 2'(k % 4)) begin
                n_bad++; $display("FAIL b2b_xact_id[%0d] got=%0d exp=%0d", k, io_acquire_bits_client_xact_id, k % 4);
            end
            n_cmp++; if (io_req_ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_req_ready_acq[%0d] got=%0b exp=0", k, io_req_ready); end
            n_cmp++; if (io_resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_prev_popped[%0d] got=%0b exp=0", k, io_resp_valid); end
            accept_acq();
            n_cmp++; if (io_req_ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_req_ready_gnt[%0d] got=%0b exp=0", k, io_req_ready); end
            send_grant(3'(k), 2'(k % 4), 4'd4, 64'hC0 + 64'(k));
            n_cmp++; if (io_resp_valid !== 1'b1 || io_resp_bits_data !== 64'hC0 + 64'(k) ||
                         io_resp_bits_beat !== 3'(k) || io_resp_bits_last !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_resp[%0d] got v=%0b data=%0h beat=%0d last=%0b exp v=1 data=%0h beat=%0d last=1",
                         k, io_resp_valid, io_resp_bits_data, io_resp_bits_beat, io_resp_bits_last, 64'hC0 + 64'(k), k);
            end
            n_cmp++; if (io_req_ready !== 1'b1)  begin n_bad++; $display("FAIL b2b_req_ready_idle[%0d] got=%0b exp=1", k, io_req_ready); end
        end
        tick();
        io_resp_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_error;
        send_req(32'h0000_4010, 1'b0);
        n_cmp++; if (io_acquire_bits_client_xact_id !== 2'd1) begin n_bad++; $display("FAIL err_xact_id got=%0d exp=1", io_acquire_bits_client_xact_id); end
        accept_acq();
        n_cmp++; if (io_error !== 1'b0) begin n_bad++; $display("FAIL err_before got=%0b exp=0", io_error); end
        send_grant(3'd2, 2'd2, 4'd4, 64'h0E44_0000);
        n_cmp++; if (io_error !== ERR_EXP) begin n_bad++; $display("FAIL err_set got=%0b exp=%0b", io_error, ERR_EXP); end
        n_cmp++; if (io_resp_valid !== 1'b1 || io_resp_bits_beat !== 3'd2 || io_resp_bits_data !== 64'h0E44_0000) begin
            n_bad++; $display("FAIL err_forwarded got v=%0b beat=%0d data=%0h exp v=1 beat=2 data=e440000", io_resp_valid, io_resp_bits_beat, io_resp_bits_data);
        end
        io_resp_ready = 1'b1;
        tick(); tick();
        io_resp_ready = 1'b0;
        n_cmp++; if (io_error !== ERR_EXP) begin n_bad++; $display("FAIL err_sticky got=%0b exp=%0b", io_error, ERR_EXP); end
        $display("test_error done");
    endtask

    task automatic test_reset_mid;
        io_resp_ready = 1'b1;
        send_req(32'h0000_5000, 1'b1);
        accept_acq();
        for (int i = 0; i < 4; i++) begin
            io_grant_valid               = 1'b1;
            io_grant_bits_addr_beat      = 3'(i);
            io_grant_bits_client_xact_id = 2'd2;
            io_grant_bits_g_type         = 4'd5;
            io_grant_bits_data           = 64'h5500 + 64'(i);
            if (i < 3) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (io_acquire_valid !== 1'b0) begin n_bad++; $display("FAIL mid_acq_valid got=%0b exp=0", io_acquire_valid); end
        n_cmp++; if (io_grant_ready !== 1'b0)   begin n_bad++; $display("FAIL mid_grant_ready got=%0b exp=0", io_grant_ready); end
        n_cmp++; if (io_resp_valid !== 1'b0)    begin n_bad++; $display("FAIL mid_resp_valid got=%0b exp=0", io_resp_valid); end
        n_cmp++; if (io_req_ready !== 1'b1)     begin n_bad++; $display("FAIL mid_req_ready got=%0b exp=1", io_req_ready); end
        n_cmp++; if (io_error !== 1'b0)         begin n_bad++; $display("FAIL mid_error got=%0b exp=0", io_error); end
        io_grant_valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        send_req(32'h0000_1008, 1'b0);
        n_cmp++; if (io_acquire_bits_client_xact_id !== 2'd0) begin n_bad++; $display("FAIL mid_new_id got=%0d exp=0", io_acquire_bits_client_xact_id); end
        n_cmp++; if (io_acquire_bits_addr_beat !== 3'd1)      begin n_bad++; $display("FAIL mid_new_beat got=%0d exp=1", io_acquire_bits_addr_beat); end
        accept_acq();
        send_grant(3'd1, 2'd0, 4'd4, 64'h7777);
        n_cmp++; if (io_resp_valid !== 1'b1 || io_resp_bits_data !== 64'h7777 || io_resp_bits_last !== 1'b1) begin
            n_bad++; $display("FAIL mid_new_resp got v=%0b data=%0h last=%0b exp v=1 data=7777 last=1", io_resp_valid, io_resp_bits_data, io_resp_bits_last);
        end
        n_cmp++; if (io_error !== 1'b0) begin n_bad++; $display("FAIL mid_new_error got=%0b exp=0", io_error); end
        tick();
        io_resp_ready = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_get();
        test_block();
        test_backpressure();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
